adc_spi_rx: RTL and testbench
=============================

Name: adc_spi_rx

Overview:
- Upstream front end for the 32-tap serial-MAC FIR filter.
- Paces the sample rate with a period counter and reads one 16-bit word per period from an external serial ADC (SPI-style: cs_n, sclk, sdo).
- Converts the word to two's complement when configured to.
- Presents the word on xOut together with a one-clock sample strobe. These drive the FIR's xIn and sample inputs directly.

Parameters:
SAMPLE_DIV, 128, clk cycles per sample period; legal range is SAMPLE_DIV > 34*SCLK_DIV, and simulation flags an error on any illegal value.
SCLK_DIV, 2, clk cycles per sclk half-period (≥1).
OFFSET_BIN, 1, 1 = ADC delivers offset binary and the block inverts MSB on output; 0 = word passes through unchanged.

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  asynchronous, active-low; asserted at 0.
en  in  1  conversion enable, level.
adc_sdo  in  1  ADC serial data, MSB first, changes after sclk falling edge.
adc_cs_n  out  1  ADC chip select, active-low.
adc_sclk  out  1  ADC serial clock, idles high.
xOut  out  16  last received sample, two's complement, held between strobes.
sample  out  1  one-clk strobe: xOut updated this cycle.
busy  out  1  high while a frame is in progress (state ≠ IDLE/WAIT).

Behaviour:
Reset (reset=0, any time):
- adc_cs_n=1, adc_sclk=1, xOut=0, sample=0, busy=0.
- State=IDLE, pcnt=0, bit counter=0, shift register=0.
- A frame in progress is aborted and no strobe is issued.

Period counter pcnt:
- Counts 0..SAMPLE_DIV-1 and wraps while en=1 or while a frame is in progress.
- Forced to 0 in IDLE when en=0.

FSM states: IDLE, SETUP, SHIFT, HOLD, WAIT. All outputs are registered.
- IDLE: cs_n=1, sclk=1. If en=1, go to SETUP next clk with pcnt=0.
- SETUP: cs_n=0, sclk=1 for SCLK_DIV clks, then go to SHIFT.
- SHIFT: 16 bit periods of 2*SCLK_DIV clks each. In each period, sclk=0 for the first SCLK_DIV clks and sclk=1 for the next SCLK_DIV clks.
  - On the clk where sclk goes 0→1, adc_sdo is shifted into the LSB of the shift register. Bit 15 is received first.
  - After bit 0 is received, go to HOLD.
- HOLD: cs_n=0, sclk=1 for SCLK_DIV clks.
  - On exit: cs_n=1, xOut <= {sr[15]^OFFSET_BIN, sr[14:0]}, and sample=1 for exactly one clk.
  - Next state is WAIT.
- WAIT: cs_n=1. When pcnt wraps to 0: go to SETUP if en=1, otherwise IDLE.

Timing with defaults:
- cs_n is low for 68 clks.
- sample asserts when pcnt=68.
- Consecutive strobes are exactly SAMPLE_DIV (128) clks apart, which is ≥32 clks as the FIR MAC needs.

Boundary conditions:
- en falls mid-frame: the frame completes, xOut and sample update normally, then the block enters IDLE with no further cs_n activity.
- en rises in WAIT: it has no effect until pcnt wraps to 0.
- en toggled 1→0→1 within WAIT: the next frame still starts at pcnt wrap.
- No overlap between frames is possible: the SAMPLE_DIV constraint guarantees HOLD ends before the wrap.
- xOut never changes except on the sample cycle or on reset.

Test Plan:
1. Reset check: hold reset=0 with adc_sdo toggling → cs_n=1, sclk=1, xOut=0, sample=0, busy=0. Release reset with en=0 for 200 clks → no sclk edges.
2. Passthrough, OFFSET_BIN=0: ADC model sends 16'hA5C3, en=1 → exactly 16 sclk rising edges while cs_n is low; cs_n is low for 68 clks; sample pulses 1 clk at pcnt=68; xOut=16'hA5C3.
3. Offset binary, OFFSET_BIN=1: codes 16'h0000, 16'hFFFF, 16'h8000 → xOut = 16'h8000, 16'h7FFF, 16'h0000 respectively.
4. Periodicity: run 10 frames → strobe spacing exactly 128 clks; xOut stable between strobes; cs_n high for 60 clks between frames.
5. Reset mid-frame: assert reset after the 8th sclk rising edge → cs_n=1 and sclk=1 immediately; no strobe; xOut=0. Release reset with en=1 → the next frame captures 16'h1234 correctly.
6. en drop mid-frame: deassert en during SHIFT → that frame still delivers its word with one strobe, then cs_n stays high and pcnt=0 indefinitely.

Source files
------------

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: sample-rate pacer and serial ADC reader feeding the FIR filter.
// Each SAMPLE_DIV-clk period one 16-bit word is clocked out of the ADC
// (MSB first). The word is optionally converted from offset binary to
// two's complement, then presented on xOut with a one-clk sample strobe.
module adc_spi_rx #(
  parameter int SAMPLE_DIV = 128,
  parameter int SCLK_DIV   = 2,
  parameter int OFFSET_BIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        adc_sdo,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] xOut,
  output logic        sample,
  output logic        busy
);

  // A frame occupies 34*SCLK_DIV clks, so the period must be strictly longer.
  if (SCLK_DIV < 1 || SAMPLE_DIV <= 34 * SCLK_DIV) begin : g_param_error
    $error("adc_spi_rx: illegal SAMPLE_DIV/SCLK_DIV combination");
  end

  localparam int   PW  = $clog2(SAMPLE_DIV);
  localparam int   DW  = $clog2(2 * SCLK_DIV);
  localparam logic INV = (OFFSET_BIN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [3:0]    bcnt, bcnt_n;
  logic [15:0]   sr;
  logic          pwrap;
  logic          shift_en;
  logic          frame_done;
  logic          active_n;

  assign pwrap    = (pcnt == PW'(SAMPLE_DIV - 1));
  assign active_n = (state_n == S_SETUP) || (state_n == S_SHIFT) || (state_n == S_HOLD);

  // Next-state and phase-counter decode for the frame sequencer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_n    = state;
    dcnt_n     = dcnt;
    bcnt_n     = bcnt;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (en) begin
          state_n = S_SETUP;
          dcnt_n  = '0;
        end
      end
      S_SETUP: begin
        if (dcnt == DW'(SCLK_DIV - 1)) begin
          state_n = S_SHIFT;
          dcnt_n  = '0;
          bcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      S_SHIFT: begin
        // Rising sclk happens at the low-to-high half boundary of each bit.
        shift_en = (dcnt == DW'(SCLK_DIV - 1));
        if (dcnt == DW'(2 * SCLK_DIV - 1)) begin
          dcnt_n = '0;
          if (bcnt == 4'd15) state_n = S_HOLD;
          else               bcnt_n  = bcnt + 1'b1;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (dcnt == DW'(SCLK_DIV - 1)) begin
          state_n    = S_WAIT;
          dcnt_n     = '0;
          frame_done = 1'b1;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      S_WAIT: begin
        // Frames only start on a period boundary, whatever en did meanwhile.
        if (pwrap) begin
          state_n = en ? S_SETUP : S_IDLE;
          dcnt_n  = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and shift register; pcnt is held at 0 while idle.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state <= S_IDLE;
      pcnt  <= '0;
      dcnt  <= '0;
      bcnt  <= '0;
      sr    <= '0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      bcnt  <= bcnt_n;
      if (state == S_IDLE) pcnt <= '0;
      else if (pwrap)      pcnt <= '0;
      else                 pcnt <= pcnt + 1'b1;
      if (shift_en) sr <= {sr[14:0], adc_sdo};
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      busy     <= 1'b0;
      sample   <= 1'b0;
      xOut     <= '0;
    end else begin
      adc_cs_n <= ~active_n;
      busy     <= active_n;
      adc_sclk <= ~((state_n == S_SHIFT) && (dcnt_n < DW'(SCLK_DIV)));
      sample   <= frame_done;
      if (frame_done) xOut <= {sr[15] ^ INV, sr[14:0]};
    end
  end

endmodule

// File: tb/tb_adc_spi_rx.sv
// Directed bench for adc_spi_rx: one instance in passthrough mode and one in
// offset-binary mode share a behavioural serial ADC driven from the first.
module tb_adc_spi_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        model_on = 1'b0;
  logic        model_bit = 1'b0;
  logic        toggle_bit = 1'b0;
  logic        adc_sdo;
  logic        cs_n0, sclk0, sample0, busy0;
  logic        cs_n1, sclk1, sample1, busy1;
  logic [15:0] x0, x1;

  assign adc_sdo = model_on ? model_bit : toggle_bit;

  adc_spi_rx #(.SAMPLE_DIV(128), .SCLK_DIV(2), .OFFSET_BIN(0)) dut_pass (
    .clk(clk), .reset(reset), .en(en), .adc_sdo(adc_sdo),
    .adc_cs_n(cs_n0), .adc_sclk(sclk0), .xOut(x0), .sample(sample0), .busy(busy0)
  );

  adc_spi_rx #(.SAMPLE_DIV(128), .SCLK_DIV(2), .OFFSET_BIN(1)) dut_ofs (
    .clk(clk), .reset(reset), .en(en), .adc_sdo(adc_sdo),
    .adc_cs_n(cs_n1), .adc_sclk(sclk1), .xOut(x1), .sample(sample1), .busy(busy1)
  );

  int     vecs = 0;
  int     errs = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial ADC: latches the word at cs_n fall, drives the next bit after each sclk fall.
  logic [15:0] adc_word = 16'h0000;
  logic [15:0] shadow = 16'h0000;
  int          bit_idx = 15;
  always @(negedge cs_n0) begin
    shadow  = adc_word;
    bit_idx = 15;
  end
  always @(negedge sclk0) begin
    if (!cs_n0 && bit_idx >= 0) begin
      model_bit = shadow[bit_idx];
      bit_idx   = bit_idx - 1;
    end
  end

  // Waits for a frame start, then records 128 clks of activity (index 0 = first cs_n low clk).
  task automatic measure_frame(input int drop_at, input int rise_at,
                               output int wait_n, output int cs_low, output int rises,
                               output int strobes, output int strobe_at, output longint strobe_time,
                               output int xchg, output int busy_bad, output bit ok);
    logic        prev_sclk;
    logic [15:0] prev_x0, prev_x1;
    wait_n = 0; cs_low = 0; rises = 0; strobes = 0; strobe_at = -1;
    strobe_time = 0; xchg = 0; busy_bad = 0; ok = 1'b0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (cs_n0 !== 1'b0 && wait_n < 400);
    if (cs_n0 !== 1'b0) begin
      vecs++; errs++;
      $display("FAIL frame_start_timeout: cs_n got %b required 0 within 400 clks", cs_n0);
      return;
    end
    ok = 1'b1;
    prev_sclk = 1'b1;
    prev_x0 = x0;
    prev_x1 = x1;
    for (int i = 0; i < 128; i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_at) en = 1'b0;
      if (i == rise_at) en = 1'b1;
      if (!cs_n0) cs_low++;
      if (!cs_n0 && !prev_sclk && sclk0) rises++;
      if (sample0) begin
        strobes++;
        strobe_at = i;
        strobe_time = cyc;
      end else if (x0 !== prev_x0 || x1 !== prev_x1) begin
        xchg++;
      end
      if (busy0 !== ~cs_n0 || busy1 !== ~cs_n1 || sample1 !== sample0) busy_bad++;
      prev_sclk = sclk0;
      prev_x0 = x0;
      prev_x1 = x1;
    end
  endtask

  task automatic test_reset;
    int edges, lows, strobes;
    logic last_sclk;
    reset = 1'b0; en = 1'b0; model_on = 1'b0;
    repeat (10) @(negedge clk) toggle_bit = ~toggle_bit;
    vecs++; if (cs_n0 !== 1'b1) begin errs++; $display("FAIL reset_cs_n: got %b required 1", cs_n0); end
    vecs++; if (sclk0 !== 1'b1) begin errs++; $display("FAIL reset_sclk: got %b required 1", sclk0); end
    vecs++; if (x0 !== 16'h0000) begin errs++; $display("FAIL reset_xout: got %h required 0000", x0); end
    vecs++; if (x1 !== 16'h0000) begin errs++; $display("FAIL reset_xout_ofs: got %h required 0000", x1); end
    vecs++; if (sample0 !== 1'b0) begin errs++; $display("FAIL reset_sample: got %b required 0", sample0); end
    vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b required 0", busy0); end
    reset = 1'b1;
    edges = 0; lows = 0; strobes = 0; last_sclk = sclk0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      toggle_bit = ~toggle_bit;
      if (sclk0 !== last_sclk || sclk1 !== 1'b1) edges++;
      if (cs_n0 !== 1'b1 || cs_n1 !== 1'b1 || busy0 !== 1'b0) lows++;
      if (sample0 !== 1'b0 || sample1 !== 1'b0) strobes++;
      last_sclk = sclk0;
    end
    vecs++; if (edges !== 0) begin errs++; $display("FAIL idle_sclk_edges: got %0d required 0", edges); end
    vecs++; if (lows !== 0) begin errs++; $display("FAIL idle_cs_activity: got %0d required 0", lows); end
    vecs++; if (strobes !== 0) begin errs++; $display("FAIL idle_strobes: got %0d required 0", strobes); end
  endtask

  task automatic test_passthrough;
    int wait_n, cs_low, rises, strobes, strobe_at, xchg, busy_bad;
    longint st;
    bit ok;
    model_on = 1'b1;
    adc_word = 16'hA5C3;
    en = 1'b1;
    measure_frame(-1, -1, wait_n, cs_low, rises, strobes, strobe_at, st, xchg, busy_bad, ok);
    if (ok) begin
      vecs++; if (wait_n !== 1) begin errs++; $display("FAIL pass_start_latency: got %0d required 1", wait_n); end
      vecs++; if (rises !== 16) begin errs++; $display("FAIL pass_sclk_rises: got %0d required 16", rises); end
      vecs++; if (cs_low !== 68) begin errs++; $display("FAIL pass_cs_low: got %0d required 68", cs_low); end
      vecs++; if (strobes !== 1) begin errs++; $display("FAIL pass_strobes: got %0d required 1", strobes); end
      vecs++; if (strobe_at !== 68) begin errs++; $display("FAIL pass_strobe_at: got %0d required 68", strobe_at); end
      vecs++; if (x0 !== 16'hA5C3) begin errs++; $display("FAIL pass_xout: got %h required a5c3", x0); end
      vecs++; if (x1 !== 16'h25C3) begin errs++; $display("FAIL pass_xout_ofs: got %h required 25c3", x1); end
      vecs++; if (busy_bad !== 0) begin errs++; $display("FAIL pass_busy: got %0d bad clks required 0", busy_bad); end
    end
  endtask

  task automatic test_offset_binary;
    logic [15:0] codes [3] = '{16'h0000, 16'hFFFF, 16'h8000};
    logic [15:0] exp1  [3] = '{16'h8000, 16'h7FFF, 16'h0000};
    int wait_n, cs_low, rises, strobes, strobe_at, xchg, busy_bad;
    longint st;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      adc_word = codes[k];
      measure_frame(-1, -1, wait_n, cs_low, rises, strobes, strobe_at, st, xchg, busy_bad, ok);
      if (ok) begin
        vecs++; if (x1 !== exp1[k]) begin errs++; $display("FAIL ofs_xout[%0d]: got %h required %h", k, x1, exp1[k]); end
        vecs++; if (x0 !== codes[k]) begin errs++; $display("FAIL ofs_pass_xout[%0d]: got %h required %h", k, x0, codes[k]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] words [10] = '{16'h1357, 16'h2468, 16'hFEDC, 16'h0001, 16'h8001,
                                16'h7FFE, 16'h3C3C, 16'hC3C3, 16'h0F0F, 16'hBEEF};
    int wait_n, cs_low, rises, strobes, strobe_at, xchg, busy_bad;
    longint st, prev_st;
    bit ok;
    prev_st = 0;
    for (int k = 0; k < 10; k++) begin
      adc_word = words[k];
      // Frame 5 toggles en low then high again inside WAIT.
      if (k == 5) measure_frame(90, 95, wait_n, cs_low, rises, strobes, strobe_at, st, xchg, busy_bad, ok);
      else        measure_frame(-1, -1, wait_n, cs_low, rises, strobes, strobe_at, st, xchg, busy_bad, ok);
      if (!ok) break;
      vecs++; if (x0 !== words[k]) begin errs++; $display("FAIL b2b_xout[%0d]: got %h required %h", k, x0, words[k]); end
      vecs++; if (x1 !== (words[k] ^ 16'h8000)) begin errs++; $display("FAIL b2b_xout_ofs[%0d]: got %h required %h", k, x1, words[k] ^ 16'h8000); end
      vecs++; if (128 - cs_low !== 60) begin errs++; $display("FAIL b2b_cs_high[%0d]: got %0d required 60", k, 128 - cs_low); end
      vecs++; if (xchg !== 0) begin errs++; $display("FAIL b2b_xout_stable[%0d]: got %0d changes required 0", k, xchg); end
      vecs++; if (wait_n !== 1) begin errs++; $display("FAIL b2b_gap[%0d]: got %0d required 1", k, wait_n); end
      if (k > 0) begin
        vecs++; if (st - prev_st !== 64'd128) begin errs++; $display("FAIL b2b_spacing[%0d]: got %0d required 128", k, st - prev_st); end
      end
      prev_st = st;
    end
  endtask

  task automatic test_en_drop;
    int wait_n, cs_low, rises, strobes, strobe_at, xchg, busy_bad, activity;
    longint st;
    bit ok;
    adc_word = 16'hC0DE;
    measure_frame(20, -1, wait_n, cs_low, rises, strobes, strobe_at, st, xchg, busy_bad, ok);
    if (ok) begin
      vecs++; if (strobes !== 1) begin errs++; $display("FAIL drop_strobes: got %0d required 1", strobes); end
      vecs++; if (x0 !== 16'hC0DE) begin errs++; $display("FAIL drop_xout: got %h required c0de", x0); end
      vecs++; if (x1 !== 16'h40DE) begin errs++; $display("FAIL drop_xout_ofs: got %h required 40de", x1); end
    end
    activity = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cs_n0 !== 1'b1 || sclk0 !== 1'b1 || sample0 !== 1'b0 || busy0 !== 1'b0) activity++;
    end
    vecs++; if (activity !== 0) begin errs++; $display("FAIL drop_idle_activity: got %0d required 0", activity); end
    // Re-enabling from IDLE must restart with pcnt=0, so the strobe lands at 68 again.
    en = 1'b1;
    adc_word = 16'h0F1E;
    measure_frame(-1, -1, wait_n, cs_low, rises, strobes, strobe_at, st, xchg, busy_bad, ok);
    if (ok) begin
      vecs++; if (wait_n !== 1) begin errs++; $display("FAIL drop_restart_latency: got %0d required 1", wait_n); end
      vecs++; if (strobe_at !== 68) begin errs++; $display("FAIL drop_restart_strobe_at: got %0d required 68", strobe_at); end
      vecs++; if (x0 !== 16'h0F1E) begin errs++; $display("FAIL drop_restart_xout: got %h required 0f1e", x0); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int wait_n, cs_low, rises, strobes, strobe_at, xchg, busy_bad, n, stray;
    longint st;
    bit ok;
    logic prev_sclk;
    adc_word = 16'hFFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cs_n0 !== 1'b0 && n < 400);
    rises = 0;
    prev_sclk = 1'b1;
    n = 0;
    while (rises < 8 && n < 100) begin
      if (!prev_sclk && sclk0) rises++;
      prev_sclk = sclk0;
      if (rises < 8) @(negedge clk);
      n++;
    end
    vecs++;
    if (rises !== 8) begin
      errs++;
      $display("FAIL midreset_reach_8th_edge: got %0d required 8", rises);
    end
    reset = 1'b0;
    #1;
    vecs++; if (cs_n0 !== 1'b1) begin errs++; $display("FAIL midreset_cs_n: got %b required 1", cs_n0); end
    vecs++; if (sclk0 !== 1'b1) begin errs++; $display("FAIL midreset_sclk: got %b required 1", sclk0); end
    vecs++; if (x0 !== 16'h0000) begin errs++; $display("FAIL midreset_xout: got %h required 0000", x0); end
    vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL midreset_busy: got %b required 0", busy0); end
    stray = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sample0 !== 1'b0 || sample1 !== 1'b0 || cs_n0 !== 1'b1) stray++;
    end
    vecs++; if (stray !== 0) begin errs++; $display("FAIL midreset_no_strobe: got %0d required 0", stray); end
    adc_word = 16'h1234;
    reset = 1'b1;
    measure_frame(-1, -1, wait_n, cs_low, rises, strobes, strobe_at, st, xchg, busy_bad, ok);
    if (ok) begin
      vecs++; if (wait_n !== 1) begin errs++; $display("FAIL midreset_restart_latency: got %0d required 1", wait_n); end
      vecs++; if (rises !== 16) begin errs++; $display("FAIL midreset_rises: got %0d required 16", rises); end
      vecs++; if (strobe_at !== 68) begin errs++; $display("FAIL midreset_strobe_at: got %0d required 68", strobe_at); end
      vecs++; if (x0 !== 16'h1234) begin errs++; $display("FAIL midreset_xout: got %h required 1234", x0); end
      vecs++; if (x1 !== 16'h9234) begin errs++; $display("FAIL midreset_xout_ofs: got %h required 9234", x1); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_offset_binary();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
